// File: rtl/writeback_stage_pkg.sv
// ============================================================================
// Module      : writeback_stage_pkg
// Description : Opcode, SYSTEM-instruction encodings and write-source type
//               shared by the writeback stage and its select logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package writeback_stage_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;

    localparam logic [31:0] INSTR_ECALL  = 32'h00000073;
    localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_MEM  = 2'd2,
        WB_SRC_LINK = 2'd3
    } wb_src_e;

    function automatic logic is_halt_instr(input logic [6:0] opcode,
                                           input logic [31:0] instr);
        return (opcode == OP_SYSTEM) &&
               ((instr == INSTR_ECALL) || (instr == INSTR_EBREAK));
    endfunction

endpackage

`default_nettype wire

// File: rtl/writeback_stage_wb_select.sv
// ============================================================================
// Module      : writeback_stage_wb_select
// Description : Chooses the register-file write value from the opcode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage_wb_select
    import writeback_stage_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [31:0] val_e,
    input  logic [31:0] val_m,
    input  logic [31:0] default_pc,
    output logic        writes_rd,
    output logic [31:0] data
);

    wb_src_e src;

    always_comb begin
        src = WB_SRC_NONE;
        case (opcode)
            OP_LOAD:                        src = WB_SRC_MEM;
            OP_JAL, OP_JALR:                src = WB_SRC_LINK;
            OP_R, OP_I, OP_LUI, OP_AUIPC:   src = WB_SRC_ALU;
            default:                        src = WB_SRC_NONE;
        endcase
    end

    always_comb begin
        writes_rd = (src != WB_SRC_NONE);
        data      = val_e;
        case (src)
            WB_SRC_MEM:  data = val_m;
            WB_SRC_LINK: data = default_pc;
            default:     data = val_e;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage: registers M results, drives the
//               register-file write port, commit trace, instret and halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int INSTRET_W      = 64,
    parameter int HALT_ON_SYSTEM = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_to_w_valid,
    output logic                 w_allow_in,
    output logic                 w_valid,
    input  logic [6:0]           M_opcode,
    input  logic [9:0]           M_funct,
    input  logic [31:0]          M_valE,
    input  logic [31:0]          m_valM,
    input  logic [4:0]           M_rd,
    input  logic [31:0]          M_default_pc,
    input  logic [31:0]          M_cur_pc,
    input  logic [31:0]          M_instr,
    input  logic                 M_commit,
    input  logic [31:0]          M_pred_pc,
    output logic                 wb_en,
    output logic [4:0]           wb_rd,
    output logic [31:0]          wb_data,
    output logic                 commit_valid,
    output logic [31:0]          commit_pc,
    output logic [31:0]          commit_instr,
    output logic [31:0]          commit_next_pc,
    output logic [INSTRET_W-1:0] instret,
    output logic                 halted
);

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    logic [6:0]  w_opcode;
    logic [9:0]  w_funct;
    logic [31:0] w_val_e;
    logic [31:0] w_val_m;
    logic [4:0]  w_rd;
    logic [31:0] w_default_pc;
    logic [31:0] w_cur_pc;
    logic [31:0] w_instr;
    logic        w_commit;
    logic [31:0] w_pred_pc;

    logic        halt_now;
    logic        writes_rd;
    logic [31:0] sel_data;
    logic        unused_funct;

    // funct is kept in W only for trace visibility; nothing consumes it here.
    assign unused_funct = ^w_funct;

    assign halt_now   = (HALT_ON_SYSTEM != 0) && w_valid &&
                        is_halt_instr(w_opcode, w_instr);
    assign w_allow_in = ~halted & ~halt_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid <= 1'b0;
            halted  <= 1'b0;
            instret <= '0;
        end else begin
            if (halt_now) begin
                w_valid <= 1'b0;
                halted  <= 1'b1;
            end else if (w_allow_in) begin
                w_valid <= m_to_w_valid;
            end
            if (commit_valid) begin
                instret <= instret + INSTRET_ONE;
            end
        end
    end

    // Payload registers carry no reset; w_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (w_allow_in && m_to_w_valid) begin
            w_opcode     <= M_opcode;
            w_funct      <= M_funct;
            w_val_e      <= M_valE;
            w_val_m      <= m_valM;
            w_rd         <= M_rd;
            w_default_pc <= M_default_pc;
            w_cur_pc     <= M_cur_pc;
            w_instr      <= M_instr;
            w_commit     <= M_commit;
            w_pred_pc    <= M_pred_pc;
        end
    end

    writeback_stage_wb_select u_wb_select (
        .opcode     (w_opcode),
        .val_e      (w_val_e),
        .val_m      (w_val_m),
        .default_pc (w_default_pc),
        .writes_rd  (writes_rd),
        .data       (sel_data)
    );

    assign commit_valid   = w_valid & w_commit;
    assign wb_en          = commit_valid & writes_rd & (w_rd != 5'd0);
    assign wb_rd          = w_rd;
    assign wb_data        = sel_data;
    assign commit_pc      = w_cur_pc;
    assign commit_instr   = w_instr;
    assign commit_next_pc = w_pred_pc;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios then random traffic, all
// compared against a slot-level reference model.
`default_nettype none

module tb_writeback_stage;

    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m_to_w_valid;
    logic          w_allow_in;
    logic          w_valid;
    logic [6:0]    M_opcode;
    logic [9:0]    M_funct;
    logic [31:0]   M_valE;
    logic [31:0]   m_valM;
    logic [4:0]    M_rd;
    logic [31:0]   M_default_pc;
    logic [31:0]   M_cur_pc;
    logic [31:0]   M_instr;
    logic          M_commit;
    logic [31:0]   M_pred_pc;
    logic          wb_en;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          commit_valid;
    logic [31:0]   commit_pc;
    logic [31:0]   commit_instr;
    logic [31:0]   commit_next_pc;
    logic [IW-1:0] instret;
    logic          halted;

    always #5 clk = ~clk;

    writeback_stage #(.INSTRET_W(IW), .HALT_ON_SYSTEM(1)) dut (
        .clk(clk), .rst(rst), .m_to_w_valid(m_to_w_valid),
        .w_allow_in(w_allow_in), .w_valid(w_valid),
        .M_opcode(M_opcode), .M_funct(M_funct), .M_valE(M_valE),
        .m_valM(m_valM), .M_rd(M_rd), .M_default_pc(M_default_pc),
        .M_cur_pc(M_cur_pc), .M_instr(M_instr), .M_commit(M_commit),
        .M_pred_pc(M_pred_pc), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_instr(commit_instr),
        .commit_next_pc(commit_next_pc), .instret(instret), .halted(halted)
    );

    typedef struct {
        bit          valid;
        logic [6:0]  opcode;
        logic [31:0] val_e;
        logic [31:0] val_m;
        logic [31:0] dpc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] npc;
        logic [4:0]  rd;
        bit          commit;
    } slot_t;

    slot_t       ms;
    bit          m_halted = 1'b0;
    int unsigned m_instret = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit m_is_halt();
        return ms.valid && (ms.instr == 32'h00000073 || ms.instr == 32'h00100073);
    endfunction

    function automatic void m_wb(input slot_t s, output bit wr, output logic [31:0] d);
        wr = 1'b1;
        d  = s.val_e;
        if (s.opcode == 7'b0000011) d = s.val_m;
        else if (s.opcode == 7'b1101111 || s.opcode == 7'b1100111) d = s.dpc;
        else if (!(s.opcode inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111})) wr = 1'b0;
    endfunction

    task automatic step();
        bit          wr;
        bit          cv;
        logic [31:0] d;
        @(posedge clk);
        if (rst) begin
            ms.valid  = 1'b0;
            m_halted  = 1'b0;
            m_instret = 0;
        end else begin
            if (ms.valid && ms.commit) m_instret = (m_instret + 1) % (1 << IW);
            if (m_is_halt()) begin
                m_halted = 1'b1;
                ms.valid = 1'b0;
            end else if (!m_halted) begin
                ms.valid = m_to_w_valid;
                if (m_to_w_valid) begin
                    ms.opcode = M_opcode;  ms.val_e = M_valE;   ms.val_m = m_valM;
                    ms.dpc    = M_default_pc; ms.pc = M_cur_pc; ms.instr = M_instr;
                    ms.npc    = M_pred_pc; ms.rd    = M_rd;     ms.commit = M_commit;
                end
            end
        end
        @(negedge clk);
        cv = ms.valid && ms.commit;
        m_wb(ms, wr, d);
        check("w_valid", w_valid, ms.valid);
        check("w_allow_in", w_allow_in, !m_halted && !m_is_halt());
        check("halted", halted, m_halted);
        check("instret", instret, m_instret);
        check("commit_valid", commit_valid, cv);
        check("wb_en", wb_en, cv && wr && ms.rd != 5'd0);
        if (ms.valid) begin
            check("wb_rd", wb_rd, ms.rd);
            if (wr) check("wb_data", wb_data, d);
        end
        if (cv) begin
            check("commit_pc", commit_pc, ms.pc);
            check("commit_instr", commit_instr, ms.instr);
            check("commit_next_pc", commit_next_pc, ms.npc);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [6:0] op, input logic [4:0] rd);
        logic [31:0] r;
        r = $urandom();
        r[6:0]  = op;
        r[11:7] = rd;
        return r;
    endfunction

    task automatic drive(input bit v, input logic [6:0] op, input logic [31:0] ins,
                         input logic [4:0] rd, input logic [31:0] ve,
                         input logic [31:0] vm, input logic [31:0] pc, input bit cm);
        m_to_w_valid = v;
        M_opcode     = op;
        M_instr      = ins;
        M_funct      = {ins[31:25], ins[14:12]};
        M_rd         = rd;
        M_valE       = ve;
        m_valM       = vm;
        M_cur_pc     = pc;
        M_default_pc = pc + 32'd4;
        M_pred_pc    = ($urandom_range(0, 3) == 0) ? $urandom() : pc + 32'd4;
        M_commit     = cm;
    endtask

    logic [6:0] ops [11] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                             7'b1110011, 7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011,
                             7'b1111111};

    task automatic drive_random();
        logic [6:0]  op;
        logic [31:0] ins;
        logic [4:0]  rd;
        int          k;
        op = ops[$urandom_range(0, 10)];
        rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom());
        ins = instr_of(op, rd);
        if (op == 7'b1110011) begin
            k = $urandom_range(0, 3);
            if (k == 0) ins = 32'h00000073;
            else if (k == 1) ins = 32'h00100073;
        end
        drive($urandom_range(0, 3) != 0, op, ins, rd, $urandom(), $urandom(),
              {$urandom_range(0, 32'h3fff), 2'b00}, $urandom_range(0, 6) != 0);
    endtask

    initial begin
        ms.valid = 1'b0;
        rst = 1'b1;
        drive(0, 7'h33, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1);
        step();
        step();
        rst = 1'b0;
        step();
        // ADD x5 = 0x12
        drive(1, 7'b0110011, instr_of(7'b0110011, 5'd5), 5'd5, 32'h12, 32'h0, 32'h40, 1);
        step();
        // LW x7 then JAL x1 at 0x100
        drive(1, 7'b0000011, instr_of(7'b0000011, 5'd7), 5'd7, 32'h80, 32'hDEADBEEF, 32'h44, 1);
        step();
        drive(1, 7'b1101111, instr_of(7'b1101111, 5'd1), 5'd1, 32'h200, 32'h0, 32'h100, 1);
        step();
        // SW, ADD x0, squashed ADD
        drive(1, 7'b0100011, instr_of(7'b0100011, 5'd3), 5'd3, 32'h10, 32'h0, 32'h104, 1);
        step();
        drive(1, 7'b0110011, instr_of(7'b0110011, 5'd0), 5'd0, 32'h99, 32'h0, 32'h108, 1);
        step();
        drive(1, 7'b0110011, instr_of(7'b0110011, 5'd9), 5'd9, 32'h77, 32'h0, 32'h10c, 0);
        step();
        // four back-to-back, then a gap
        for (int i = 0; i < 4; i++) begin
            drive(1, 7'b0010011, instr_of(7'b0010011, 5'(i + 10)), 5'(i + 10),
                  $urandom(), 32'h0, 32'h200 + 32'(4 * i), 1);
            step();
        end
        drive(0, 7'b0010011, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1);
        step();
        step();
        // ECALL followed by an ADD held valid
        drive(1, 7'b1110011, 32'h00000073, 5'd0, 32'h0, 32'h0, 32'h300, 1);
        step();
        drive(1, 7'b0110011, instr_of(7'b0110011, 5'd4), 5'd4, 32'h55, 32'h0, 32'h304, 1);
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        // random traffic with occasional resets; instret wraps at 2^IW
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 59) == 0) || (m_halted && $urandom_range(0, 5) == 0);
            drive_random();
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final stage of the 5-stage RISC-V pipeline, directly downstream of the memory-access stage. It accepts one instruction per cycle over the valid/allow_in handshake and registers it with its memory read data. It then selects the register-file write value, drives the register-file write port and forwarding, and reports commit information. It also keeps a retired-instruction counter and a sticky halt on ECALL/EBREAK.

Parameters:
INSTRET_W, 64, width of retired-instruction counter (wraps modulo 2^INSTRET_W)
HALT_ON_SYSTEM, 1, 1 = ECALL/EBREAK halts the pipeline; 0 = treated as no-write instruction

Ports:
clk  in  1  clock
rst  in  1  reset
m_to_w_valid  in  1  memory stage holds a valid instruction for W
w_allow_in  out  1  W can accept this cycle
w_valid  out  1  W register holds a valid instruction
M_opcode  in  7  opcode
M_funct  in  10  funct (carried only, for trace)
M_valE  in  32  ALU result
m_valM  in  32  load data, already sized/extended by data RAM
M_rd  in  5  destination register
M_default_pc  in  32  pc+4
M_cur_pc  in  32  instruction pc
M_instr  in  32  raw instruction
M_commit  in  1  instruction is architecturally committed (not squashed)
M_pred_pc  in  32  resolved next pc
wb_en  out  1  register-file write enable
wb_rd  out  5  register-file write address
wb_data  out  32  register-file write data
commit_valid  out  1  one instruction retires this cycle
commit_pc  out  32  retiring pc
commit_instr  out  32  retiring instruction
commit_next_pc  out  32  next pc after retiring instruction
instret  out  INSTRET_W  retired-instruction count
halted  out  1  sticky halt flag

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. On reset w_valid=0, halted=0, instret=0. All derived outputs (wb_en, commit_valid) are therefore 0. W data registers are not reset.
- w_ready_go=1. halt_now = HALT_ON_SYSTEM & w_valid & W_opcode==7'b1110011 & (W_instr==32'h00000073 | W_instr==32'h00100073).
- w_allow_in = ~halted & ~halt_now.
- Valid update: if rst, w_valid<=0. Else if halt_now, w_valid<=0. Else if w_allow_in, w_valid<=m_to_w_valid.
- Data capture: when w_allow_in & m_to_w_valid, register W_opcode, W_funct, W_valE, W_valM (captured from m_valM at the same edge), W_rd, W_default_pc, W_cur_pc, W_instr, W_commit, W_pred_pc. Otherwise hold.
- Latency: an instruction is presented on wb_*/commit_* one cycle after the handshake edge, for exactly one cycle.
- Write select (combinational from W regs):
  - LOAD 0000011 -> W_valM
  - JAL 1101111 / JALR 1100111 -> W_default_pc
  - OP, OP-IMM, LUI, AUIPC -> W_valE
  - STORE 0100011, BRANCH 1100011, SYSTEM, unknown -> no write
- wb_en = w_valid & W_commit & writes_rd & (W_rd!=0). wb_rd=W_rd and wb_data=selected value, driven regardless of wb_en.
- commit_valid = w_valid & W_commit; commit_pc/instr/next_pc from W regs. A squashed instruction (W_commit=0) consumes the slot, with no write and no commit.
- instret += 1 on each cycle with commit_valid; wraps from all-ones to 0.
- Halt: halted<=1 at the edge where halt_now. The halting instruction itself commits and counts in instret. Halt is sticky until rst. While halted, w_allow_in=0 (backpressures M) and w_valid=0.
- rst asserted mid-stream drops the in-flight W instruction, with no commit at that edge.

Decomposition:
- Opcode constants (OP_LOAD, OP_S, OP_B, OP_JAL, OP_JALR, OP_SYSTEM, OP_LUI, OP_AUIPC, OP_R, OP_I) live in the shared define.v; no local literals.
- ECALL/EBREAK encodings are added to define.v.
- One combinational sub-module, wb_select (opcode, valE, valM, default_pc -> writes_rd, data).

Test Plan:
- Reset then ADD x5 result valE=0x12 via handshake -> next cycle wb_en=1, wb_rd=5, wb_data=0x12, commit_valid=1, instret=1.
- LW x7, m_valM=0xDEADBEEF; then JAL x1 at pc 0x100 (default_pc 0x104) -> wb_data 0xDEADBEEF, then 0x104 on consecutive cycles.
- SW, then ADD with rd=x0, then M_commit=0 instr -> wb_en=0 for all three; commit_valid=1,1,0; instret +2.
- m_to_w_valid back-to-back 4 instrs, then 1-cycle gap -> 4 consecutive commits, w_valid low one cycle, w_allow_in always 1.
- ECALL followed by ADD held valid -> ECALL commits, halted=1 next edge, w_allow_in=0 forever, ADD never commits; rst clears halted and instret.
- Preload instret to all-ones (force) and commit one -> instret=0.
